// File: rtl/pwm_pattern_sequencer.sv
// pwm_pattern_sequencer: plays a 16x32 pattern table onto two PWM regs over an AXI4-Lite write master.
// Ports: ACLK/ARESETN; start/stop/loop_en run control; cfg_we/cfg_addr/cfg_data table write;
//        busy/done/err/step_idx status; M_AXI_AW*/W*/B* write-only master.
// Option: define PWM_SEQ_SILENCE_EN to write duty 0 to reg1 before finishing a run.

module pwm_pattern_sequencer #(
  parameter logic [31:0] C_BASE_ADDR = 32'h43C0_0000,
  parameter int unsigned C_TICK_DIV  = 50000
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  step_idx,
  output logic [31:0] M_AXI_AWADDR,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_FETCH = 4'd1;
  localparam logic [3:0] S_WR0   = 4'd2;
  localparam logic [3:0] S_B0    = 4'd3;
  localparam logic [3:0] S_WR1   = 4'd4;
  localparam logic [3:0] S_B1    = 4'd5;
  localparam logic [3:0] S_HOLD  = 4'd6;
`ifdef PWM_SEQ_SILENCE_EN
  localparam logic [3:0] S_SIL   = 4'd7;
  localparam logic [3:0] S_SILB  = 4'd8;
`endif

  logic [31:0] tbl_q [16];

  logic [3:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] ent_q, ent_d;
  logic [31:0] tick_q, tick_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        stop_pend_q, stop_pend_d;

  logic        aw_left, w_left, go_end;
  logic [31:0] cur;
  logic [31:0] hold_len;

  assign cur      = tbl_q[idx_q];
  // HOLD counts down to zero, so load one less than the cycle count
  assign hold_len = 32'(ent_q[31:24]) * 32'(C_TICK_DIV) - 32'd1;
  assign aw_left  = awvalid_q & ~M_AXI_AWREADY;
  assign w_left   = wvalid_q & ~M_AXI_WREADY;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ent_d       = ent_q;
    tick_d      = tick_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    done_d      = 1'b0;
    err_d       = err_q;
    stop_pend_d = stop_pend_q;
    go_end      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d     = S_FETCH;
          idx_d       = 4'd0;
          err_d       = 1'b0;
          stop_pend_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (stop || cur[31:24] == 8'd0) begin
          go_end = 1'b1;
        end else begin
          ent_d     = cur;
          state_d   = S_WR0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end
      end
      S_WR0, S_WR1: begin
        awvalid_d   = aw_left;
        wvalid_d    = w_left;
        stop_pend_d = stop_pend_q | stop;
        if (!aw_left && !w_left)
          state_d = (state_q == S_WR0) ? S_B0 : S_B1;
      end
      S_B0, S_B1: begin
        stop_pend_d = stop_pend_q | stop;
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (stop_pend_q || stop) begin
            go_end = 1'b1;
          end else if (state_q == S_B0) begin
            state_d   = S_WR1;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d = S_HOLD;
            tick_d  = hold_len;
          end
        end
      end
      S_HOLD: begin
        if (stop) begin
          go_end = 1'b1;
        end else if (tick_q != 32'd0) begin
          tick_d = tick_q - 32'd1;
        end else if (idx_q == 4'hF && !loop_en) begin
          go_end = 1'b1;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_FETCH;
        end
      end
`ifdef PWM_SEQ_SILENCE_EN
      S_SIL: begin
        awvalid_d = aw_left;
        wvalid_d  = w_left;
        if (!aw_left && !w_left)
          state_d = S_SILB;
      end
      S_SILB: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00)
            err_d = 1'b1;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (go_end) begin
      stop_pend_d = 1'b0;
`ifdef PWM_SEQ_SILENCE_EN
      state_d     = S_SIL;
      awvalid_d   = 1'b1;
      wvalid_d    = 1'b1;
`else
      state_d     = S_IDLE;
      done_d      = 1'b1;
`endif
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      ent_q       <= 32'd0;
      tick_q      <= 32'd0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ent_q       <= ent_d;
      tick_q      <= tick_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // table is plain storage and survives reset
  always_ff @(posedge ACLK) begin
    if (cfg_we)
      tbl_q[cfg_addr] <= cfg_data;
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign step_idx      = idx_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_AWADDR  = (state_q == S_WR0) ? C_BASE_ADDR
                                            : C_BASE_ADDR + 32'd4;
  assign M_AXI_WDATA   = (state_q == S_WR0) ? {16'h0, ent_q[15:0]}  :
                         (state_q == S_WR1) ? {24'h0, ent_q[23:16]} :
                                              32'h0;
`ifdef PWM_SEQ_SILENCE_EN
  assign M_AXI_BREADY  = (state_q == S_B0) || (state_q == S_B1) ||
                         (state_q == S_SILB);
`else
  assign M_AXI_BREADY  = (state_q == S_B0) || (state_q == S_B1);
`endif

endmodule

// File: doc/pwm_pattern_sequencer.md
PWM_PATTERN_SEQUENCER -- requirements
Module: pwm_pattern_sequencer

Interface
REQ-001 SHALL have parameter C_BASE_ADDR, default 32'h43C0_0000, the AXI byte address of PWM register 0.
REQ-002 SHALL have parameter C_TICK_DIV, default 50000, the ACLK cycles per duration tick, range 1..2^24-1.
REQ-003 SHALL have port ACLK, input, 1, the single clock for all logic.
REQ-004 SHALL have port ARESETN, input, 1, the reset; asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, a one-cycle request to run the pattern from entry 0.
REQ-006 SHALL have port stop, input, 1, a one-cycle request to abort the run.
REQ-007 SHALL have port loop_en, input, 1, which wraps the pattern after entry 15 when high.
REQ-008 SHALL have port cfg_we / cfg_addr / cfg_data, input, 1/4/32, the pattern table write port.
REQ-009 SHALL have port busy / done / err / step_idx, output, 1/1/1/4, giving run status, end pulse, sticky error and current entry.
REQ-010 SHALL have AXI4-Lite write master ports M_AXI_AWADDR[31:0], AWPROT[2:0], AWVALID, AWREADY, WDATA[31:0], WSTRB[3:0], WVALID, WREADY, BRESP[1:0], BVALID and BREADY, with directions per AXI4-Lite master; there is no read channel.

Function
REQ-011 SHALL hold a 16x32 pattern table: entry[15:0] goes to PWM reg0 (period), entry[23:16] zero-extended goes to reg1 (duty), and entry[31:24] is the duration in ticks; a duration of 0 marks end-of-pattern.
REQ-012 SHALL write the table on cfg_we at any time; a write during a run takes effect the next time that entry is fetched.
REQ-013 SHALL implement the FSM states IDLE, FETCH, WR0, B0, WR1, B1, HOLD, SIL, SILB.
REQ-014 SHALL transition IDLE->FETCH on start when stop is low; start while busy is ignored.
REQ-015 SHALL, in FETCH, go to the end sequence if duration==0 and otherwise to WR0; no AXI traffic occurs for an end marker.
REQ-016 SHALL, in WR0/WR1, assert AWVALID and WVALID together in the first cycle; each drops independently on its own READY; the state advances once both handshakes are done, even if they complete in different cycles.
REQ-017 SHALL drive AWADDR = C_BASE_ADDR in WR0 and C_BASE_ADDR+4 in WR1, with AWPROT=0 and WSTRB=4'hF.
REQ-018 SHALL hold BREADY high only in B0/B1/SILB; BVALID with BRESP!=OKAY sets err and goes straight to IDLE with no silence write.
REQ-019 SHALL, in HOLD, wait exactly duration*C_TICK_DIV cycles after the B1 handshake, then increment step_idx.
REQ-020 SHALL, after entry 15, wrap to 0 when loop_en=1 and otherwise run the end sequence.
REQ-021 SHALL, on stop in HOLD or FETCH, run the end sequence next cycle; on stop in WR*/B*, finish the outstanding transaction and then run the end sequence, never withdrawing a VALID once asserted.
REQ-022 SHALL give stop priority over start in the same cycle; stop in IDLE has no effect.
REQ-023 SHALL define the end sequence as: optional silence (see Configuration), then IDLE with done high for exactly 1 cycle.
REQ-024 SHALL hold busy=1 in every state except IDLE; err clears only on an accepted start.

Reset
REQ-025 SHALL, on ARESETN low, immediately set state=IDLE, AWVALID=WVALID=BREADY=0, busy=done=err=0, step_idx=0 and the tick counter to 0; the pattern table is not reset.
REQ-026 SHALL, on reset mid-transaction, drop VALIDs asynchronously (legal under AXI reset rules); after release no B response is awaited.

Configuration
REQ-027 SHALL, with macro PWM_SEQ_SILENCE_EN defined, have the end sequence write 32'h0 to C_BASE_ADDR+4 (SIL/SILB) before IDLE, with done after the B handshake and a non-OKAY response setting err.
REQ-028 SHALL, without PWM_SEQ_SILENCE_EN, omit SIL/SILB, go directly to IDLE, and leave the PWM registers holding their last values.

Verification
REQ-029 SHALL cover: C_TICK_DIV=4, entry0=32'h0280_1234, entry1=0, start -> writes 0x1234@base, 0x80@base+4, 8 cycles hold, done pulse, busy low.
REQ-030 SHALL cover: an AWREADY 3 cycles after WREADY on WR0 -> single write issued, VALIDs stable until each READY.
REQ-031 SHALL cover: BRESP=2'b10 on B1 -> err=1, IDLE, no further writes; the next start clears err.
REQ-032 SHALL cover: all 16 entries with nonzero duration and loop_en=1, stop mid-HOLD of entry 3 after a wrap -> step_idx=3, silence write 0 (macro on) or none (macro off), then done.
REQ-033 SHALL cover: start and stop in the same cycle in IDLE -> no AXI activity, busy stays 0.
REQ-034 SHALL cover: ARESETN low while AWVALID=1 -> AWVALID=0 in the same cycle, all outputs at reset values, and a fresh start after release runs from entry 0.
